// File: rtl/gsim_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gsim_ctrl
// Purpose  : Gauss-Seidel solve controller. Loads each linear system
//            (N rows of A, then B) from matrix memory into an operand buffer.
//            It hands the buffer to an external solver through a start/done
//            handshake and streams every solution vector X to result memory.
// Option   : GSIM_CTRL_PINGPONG_EN -- two alternating operand buffers, so the
//            next system loads while the current one solves. When it is not
//            defined there is one buffer and loading waits for solver done.
// Revision : 1.0 - initial release
// ============================================================================
module gsim_ctrl #(
    parameter int N       = 16,
    parameter int ELEM_W  = 16,
    parameter int X_W     = 32,
    parameter int MADDR_W = 10,
    parameter int XADDR_W = 9,
    parameter int CNT_W   = 5
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_module_en,
    input  logic [CNT_W-1:0]           i_matrix_num,
    output logic                       o_proc_done,
    output logic                       o_mem_rreq,
    output logic [MADDR_W-1:0]         o_mem_addr,
    input  logic                       i_mem_rrdy,
    input  logic [N*ELEM_W-1:0]        i_mem_dout,
    input  logic                       i_mem_dout_vld,
    output logic                       o_solv_start,
    output logic [N*N*ELEM_W-1:0]      o_solv_a,
    output logic [N*ELEM_W-1:0]        o_solv_b,
    input  logic                       i_solv_done,
    input  logic [N*X_W-1:0]           i_solv_x,
    output logic                       o_x_wen,
    output logic [XADDR_W-1:0]         o_x_addr,
    output logic [X_W-1:0]             o_x_data
);

    localparam int ROW_W = N * ELEM_W;
    localparam int KW    = $clog2(N + 1);
    localparam int IW    = (N > 1) ? $clog2(N) : 1;
`ifdef GSIM_CTRL_PINGPONG_EN
    localparam int NBUF  = 2;
`else
    localparam int NBUF  = 1;
`endif

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} top_state_t;
    typedef enum logic [1:0] {L_IDLE = 2'd0, L_REQ = 2'd1, L_WAIT = 2'd2} ld_state_t;

    top_state_t          top_state;
    ld_state_t           ld_state;
    logic [CNT_W-1:0]    mat_total;
    logic [CNT_W-1:0]    load_cnt;
    logic [CNT_W-1:0]    done_cnt;
    logic [KW-1:0]       word_k;
    logic                load_buf;
    logic                solve_buf;
    logic [NBUF-1:0]     buf_full;
    logic                solving;
    logic [N*X_W-1:0]    x_latch;
    logic [IW-1:0]       stream_i;
    logic [XADDR_W-1:0]  wr_ptr;
    logic [ROW_W-1:0]    buf_mem [NBUF][N+1];

    logic run_go;
    logic load_fin;
    logic free_now;
    logic issue;
    logic stream_last;

    assign run_go      = (top_state == S_IDLE) && i_module_en && (i_matrix_num != '0);
    assign load_fin    = (ld_state == L_WAIT) && i_mem_dout_vld && (word_k == KW'(N));
    assign free_now    = i_solv_done && solving;
    assign issue       = (top_state == S_RUN) && buf_full[solve_buf] && !solving && !o_x_wen;
    assign stream_last = o_x_wen && (stream_i == IW'(N - 1));
    assign o_solv_start = issue;

    // Operands are presented from the buffer next in solve order; zero while it holds no system
    generate
        for (genvar r = 0; r < N; r++) begin : g_rows
            assign o_solv_a[r*ROW_W +: ROW_W] = buf_full[solve_buf] ? buf_mem[solve_buf][r] : '0;
        end
    endgenerate
    assign o_solv_b = buf_full[solve_buf] ? buf_mem[solve_buf][N] : '0;

    // Top-level run control: start, completion and hand-back to idle
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            top_state   <= S_IDLE;
            mat_total   <= '0;
            done_cnt    <= '0;
            o_proc_done <= 1'b0;
        end else begin
            case (top_state)
                S_IDLE: begin
                    if (i_module_en) begin
                        mat_total <= i_matrix_num;
                        done_cnt  <= '0;
                        if (i_matrix_num == '0) begin
                            top_state   <= S_DONE;
                            o_proc_done <= 1'b1;
                        end else begin
                            top_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (stream_last) begin
                        done_cnt <= done_cnt + 1'b1;
                        if (done_cnt + 1'b1 == mat_total) begin
                            top_state   <= S_DONE;
                            o_proc_done <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (!i_module_en) begin
                        top_state   <= S_IDLE;
                        o_proc_done <= 1'b0;
                    end
                end
                default: top_state <= S_IDLE;
            endcase
        end
    end

    // Loader: one outstanding word request at a time into the next free buffer
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ld_state   <= L_IDLE;
            o_mem_rreq <= 1'b0;
            o_mem_addr <= '0;
            word_k     <= '0;
            load_buf   <= 1'b0;
            load_cnt   <= '0;
        end else if (run_go) begin
            ld_state   <= L_IDLE;
            o_mem_rreq <= 1'b0;
            o_mem_addr <= '0;
            word_k     <= '0;
            load_buf   <= 1'b0;
            load_cnt   <= '0;
        end else begin
            case (ld_state)
                L_IDLE: begin
                    if ((top_state == S_RUN) && (load_cnt < mat_total) && !buf_full[load_buf]) begin
                        ld_state   <= L_REQ;
                        o_mem_rreq <= 1'b1;
                        word_k     <= '0;
                    end
                end
                L_REQ: begin
                    if (i_mem_rrdy) begin
                        ld_state   <= L_WAIT;
                        o_mem_rreq <= 1'b0;
                    end
                end
                L_WAIT: begin
                    if (i_mem_dout_vld) begin
                        // Matrices are contiguous, so the address simply keeps counting
                        o_mem_addr <= o_mem_addr + 1'b1;
                        if (word_k == KW'(N)) begin
                            ld_state <= L_IDLE;
                            load_cnt <= load_cnt + 1'b1;
`ifdef GSIM_CTRL_PINGPONG_EN
                            load_buf <= ~load_buf;
`endif
                        end else begin
                            ld_state   <= L_REQ;
                            o_mem_rreq <= 1'b1;
                            word_k     <= word_k + 1'b1;
                        end
                    end
                end
                default: ld_state <= L_IDLE;
            endcase
        end
    end

    // Operand storage; validity is tracked separately by buf_full
    always_ff @(posedge i_clk) begin
        if ((ld_state == L_WAIT) && i_mem_dout_vld) begin
            buf_mem[load_buf][word_k] <= i_mem_dout;
        end
    end

    // Buffer occupancy, solve tracking and result streaming
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            buf_full  <= '0;
            solving   <= 1'b0;
            solve_buf <= 1'b0;
            x_latch   <= '0;
            stream_i  <= '0;
            wr_ptr    <= '0;
            o_x_wen   <= 1'b0;
            o_x_addr  <= '0;
            o_x_data  <= '0;
        end else if (run_go) begin
            buf_full  <= '0;
            solving   <= 1'b0;
            solve_buf <= 1'b0;
            wr_ptr    <= '0;
        end else begin
            if (load_fin) begin
                buf_full[load_buf] <= 1'b1;
            end
            if (issue) begin
                solving <= 1'b1;
            end
            if (free_now) begin
                solving             <= 1'b0;
                buf_full[solve_buf] <= 1'b0;
`ifdef GSIM_CTRL_PINGPONG_EN
                solve_buf           <= ~solve_buf;
`endif
                // Element 0 goes out immediately; the rest shift down one per cycle
                o_x_wen  <= 1'b1;
                o_x_addr <= wr_ptr;
                o_x_data <= i_solv_x[X_W-1:0];
                x_latch  <= i_solv_x >> X_W;
                stream_i <= '0;
            end else if (o_x_wen) begin
                if (stream_last) begin
                    o_x_wen <= 1'b0;
                    wr_ptr  <= o_x_addr + 1'b1;
                end else begin
                    stream_i <= stream_i + 1'b1;
                    o_x_addr <= o_x_addr + 1'b1;
                    o_x_data <= x_latch[X_W-1:0];
                    x_latch  <= x_latch >> X_W;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gsim_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gsim_ctrl
// Purpose  : Self-checking bench for gsim_ctrl. It models the matrix memory
//            and the solver, and a scoreboard queue holds the expected result
//            writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gsim_ctrl;

    localparam int N   = 16;
    localparam int EW  = 16;
    localparam int XW  = 32;
    localparam int MAW = 10;
    localparam int XAW = 9;
    localparam int CW  = 5;
    localparam int RW  = N * EW;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              en = 1'b0;
    logic [CW-1:0]     mnum = '0;
    logic              proc_done;
    logic              rreq;
    logic [MAW-1:0]    maddr;
    logic              rrdy = 1'b0;
    logic [RW-1:0]     mdout = '0;
    logic              mvld = 1'b0;
    logic              sstart;
    logic [N*RW-1:0]   sa;
    logic [RW-1:0]     sb;
    logic              sdone = 1'b0;
    logic [N*XW-1:0]   sx = '0;
    logic              xwen;
    logic [XAW-1:0]    xaddr;
    logic [XW-1:0]     xdata;

    gsim_ctrl #(.N(N), .ELEM_W(EW), .X_W(XW), .MADDR_W(MAW), .XADDR_W(XAW), .CNT_W(CW)) dut (
        .i_clk(clk), .i_reset(reset), .i_module_en(en), .i_matrix_num(mnum),
        .o_proc_done(proc_done), .o_mem_rreq(rreq), .o_mem_addr(maddr),
        .i_mem_rrdy(rrdy), .i_mem_dout(mdout), .i_mem_dout_vld(mvld),
        .o_solv_start(sstart), .o_solv_a(sa), .o_solv_b(sb),
        .i_solv_done(sdone), .i_solv_x(sx),
        .o_x_wen(xwen), .o_x_addr(xaddr), .o_x_data(xdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endfunction

    // Solution rule shared by the solver model and the reference model
    function automatic logic [XW-1:0] fx(input logic [RW-1:0] row, input logic [RW-1:0] b, input int i);
        logic [15:0] lo;
        lo = row[15:0] + b[RW-1:RW-16] + 16'(i);
        return {row[RW-1:RW-16] ^ b[15:0], lo};
    endfunction

    logic [RW-1:0] mem [1024];

    typedef struct {
        logic [XAW-1:0] a;
        logic [XW-1:0]  d;
    } exp_t;
    exp_t expq[$];

    // environment configuration and bookkeeping
    int          mem_lat = 2;
    int          solv_lat = 20;
    bit          rrdy_rand = 0;
    bit          stall_en = 0;
    int          pend = 0;
    logic [MAW-1:0] pend_addr = '0;
    int          acc_total = 0;
    int          req_cnt [1024];
    int          acc_before_done = 0;
    bit          first_done_seen = 0;
    int          sol_cnt = 0;
    bit          sol_busy = 0;
    logic [N*XW-1:0] sol_x;
    logic [N*RW-1:0] cap_a;
    logic [RW-1:0]   cap_b;
    int          starts = 0;
    int          rreq_in_solve = 0;
    int          stall_cnt = 0;
    bit          spur_done = 0;
    int          last_wen_cyc = 0;

    task automatic env_clear();
        pend = 0; acc_total = 0; starts = 0; rreq_in_solve = 0;
        first_done_seen = 0; acc_before_done = 0; stall_cnt = 0;
        sol_busy = 0; spur_done = 0;
        foreach (req_cnt[a]) req_cnt[a] = 0;
    endtask

    // Memory and solver models, driven away from the active edge
    always @(negedge clk) begin
        mvld = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                mvld  = 1'b1;
                mdout = mem[pend_addr];
            end
        end
        if (stall_cnt > 0 && stall_cnt < 5) begin
            chk("stall_rreq_held", rreq, 1);
            chk("stall_addr_held", maddr, 5);
            rrdy = 1'b0;
            if (stall_cnt == 2 && pend == 0) begin
                mvld  = 1'b1;
                mdout = {8{$urandom}};
            end
            stall_cnt++;
        end else if (stall_en && stall_cnt == 0 && rreq && maddr == 10'd5) begin
            rrdy = 1'b0;
            stall_cnt = 1;
        end else begin
            rrdy = rrdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (rreq && rrdy && !reset) begin
            chk("one_outstanding", pend, 0);
            acc_total++;
            req_cnt[maddr]++;
            pend_addr = maddr;
            pend = (mem_lat == 0) ? $urandom_range(1, 3) : mem_lat;
            if (!first_done_seen) acc_before_done++;
        end

        sdone = 1'b0;
        if (sol_busy) begin
            if (rreq) rreq_in_solve++;
            sol_cnt--;
            if (sol_cnt == 0) begin
                chk("solv_operands_stable", ({sa, sb} === {cap_a, cap_b}), 1);
                sdone = 1'b1;
                sx = sol_x;
                sol_busy = 0;
                first_done_seen = 1;
            end
        end else if (spur_done) begin
            sdone = 1'b1;
            sx = {16{$urandom}};
            spur_done = 0;
        end
        if (sstart) begin
            starts++;
            chk("start_while_busy", sol_busy, 0);
            cap_a = sa;
            cap_b = sb;
            for (int i = 0; i < N; i++) sol_x[i*XW +: XW] = fx(sa[i*RW +: RW], sb, i);
            sol_cnt = solv_lat;
            sol_busy = 1;
            if (rreq) rreq_in_solve++;
        end
    end

    // Scoreboard monitor: every result write must match the head of the queue
    always @(negedge clk) begin
        exp_t e;
        if (xwen) begin
            last_wen_cyc = cyc;
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write addr=%0h data=%0h expected no write", xaddr, xdata);
            end else begin
                e = expq.pop_front();
                chk("x_addr", xaddr, e.a);
                chk("x_data", xdata, e.d);
            end
        end
    end

    task automatic check_zero(string tag);
        chk({tag, "_rreq"}, rreq, 0);
        chk({tag, "_addr"}, maddr, 0);
        chk({tag, "_start"}, sstart, 0);
        chk({tag, "_solv_a"}, |sa, 0);
        chk({tag, "_solv_b"}, |sb, 0);
        chk({tag, "_wen"}, xwen, 0);
        chk({tag, "_xaddr"}, xaddr, 0);
        chk({tag, "_xdata"}, xdata, 0);
        chk({tag, "_done"}, proc_done, 0);
    endtask

    task automatic run(input int m, input int lat, input int slat, input bit rr,
                       input bit st, input bit toggle_en);
        int k;
        int bad;
        exp_t e;
        @(negedge clk);
        #1;
        env_clear();
        mem_lat = lat; solv_lat = slat; rrdy_rand = rr; stall_en = st;
        for (int mm = 0; mm < m; mm++) begin
            for (int i = 0; i < N; i++) begin
                e.a = XAW'(mm * N + i);
                e.d = fx(mem[mm*(N+1) + i], mem[mm*(N+1) + N], i);
                expq.push_back(e);
            end
        end
        mnum = CW'(m);
        en = 1'b1;
        k = 0;
        while (!proc_done && k < 20000) begin
            @(negedge clk);
            k++;
            if (toggle_en && k == 50) en = 1'b0;
            if (toggle_en && k == 60) en = 1'b1;
        end
        chk("proc_done_timeout", proc_done, 1);
        if (m == 0) chk("m0_done_latency", k, 1);
        else        chk("done_after_last_wen", cyc - last_wen_cyc, 1);
        chk("queue_drained", expq.size(), 0);
        chk("start_count", starts, m);
        chk("req_total", acc_total, m * (N + 1));
        bad = 0;
        for (int a = 0; a < m * (N + 1); a++) if (req_cnt[a] != 1) bad++;
        chk("req_each_once", bad, 0);
`ifdef GSIM_CTRL_PINGPONG_EN
        if (m > 1 && slat >= 300) chk("prefetch_before_done", acc_before_done >= 2 * (N + 1), 1);
`else
        if (m > 0) chk("no_rreq_during_solve", rreq_in_solve, 0);
`endif
        if (m == 0) begin
            spur_done = 1;
            repeat (3) @(negedge clk);
            chk("m0_done_hold", proc_done, 1);
        end
        #1 en = 1'b0;
        @(negedge clk);
        chk("done_drop", proc_done, 0);
        expq.delete();
    endtask

    initial begin
        int k;
        env_clear();
        for (int a = 0; a < 1024; a++)
            for (int j = 0; j < 8; j++) mem[a][j*32 +: 32] = $urandom;

        repeat (3) @(negedge clk);
        check_zero("reset");
        #1 reset = 1'b0;

        run(1, 2, 20, 0, 0, 0);
        run(3, 0, 300, 1, 0, 1);
        run(1, 2, 20, 0, 1, 0);
        run(0, 2, 20, 0, 0, 0);
        run(1, 2, 20, 0, 0, 0);

        // Reset while the loader waits for read data
        @(negedge clk);
        #1;
        env_clear();
        mem_lat = 10; solv_lat = 20; rrdy_rand = 0; stall_en = 0;
        mnum = CW'(1);
        en = 1'b1;
        k = 0;
        while (acc_total == 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("first_accept_seen", acc_total, 1);
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        en = 1'b0;
        @(negedge clk);
        check_zero("midreset");
        expq.delete();
        @(negedge clk);
        #1 reset = 1'b0;
        repeat (15) @(negedge clk);
        chk("no_req_after_reset", acc_total, 1);
        chk("idle_rreq_after_reset", rreq, 0);
        chk("idle_start_after_reset", starts, 0);

        run(2, 1, 40, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
